// File: rtl/branch_resolution_unit.sv
// Decode-stage branch resolution: carries fetch predictions into Decode, detects mispredicts,
// drives flush/redirect, issues registered predictor updates and keeps saturating counters.
module branch_resolution_unit #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_D,
    input  logic              pred_taken_F,
    input  logic [ADDR_W-1:0] pred_target_F,
    input  logic [ADDR_W-1:0] PC_F,
    input  logic [ADDR_W-1:0] PCPlus4_F,
    input  logic              Branch_D,
    input  logic              branch_taken_D,
    input  logic [ADDR_W-1:0] PCBranch_D,
    output logic              flush_D,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              update_en,
    output logic [ADDR_W-1:0] update_pc,
    output logic [ADDR_W-1:0] update_target,
    output logic              update_taken,
    output logic [CNT_W-1:0]  branch_cnt,
    output logic [CNT_W-1:0]  mispredict_cnt
);

    logic              vld_q, vld_d;
    logic              pred_taken_q, pred_taken_d;
    logic [ADDR_W-1:0] pred_target_q, pred_target_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pc_plus4_q, pc_plus4_d;

    logic              upd_en_q, upd_en_d;
    logic [ADDR_W-1:0] upd_pc_q, upd_pc_d;
    logic [ADDR_W-1:0] upd_target_q, upd_target_d;
    logic              upd_taken_q, upd_taken_d;

    logic [CNT_W-1:0]  branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0]  mispredict_cnt_q, mispredict_cnt_d;

    logic resolve;
    logic m1, m2, m3, m4;
    logic mispredict;
    logic issue_update;

    always_comb begin
        resolve    = vld_q & ~stall_D;
        m1         = resolve & Branch_D & pred_taken_q & ~branch_taken_D;
        m2         = resolve & Branch_D & ~pred_taken_q & branch_taken_D;
        m3         = resolve & Branch_D & pred_taken_q & branch_taken_D &
                     (pred_target_q != PCBranch_D);
        m4         = resolve & ~Branch_D & pred_taken_q;
        mispredict = m1 | m2 | m3 | m4;

        flush_D        = mispredict;
        redirect_valid = mispredict;
        redirect_pc    = (m2 | m3) ? PCBranch_D : pc_plus4_q;

        // A predicted-taken non-branch is a BTB alias and must be trained away too.
        issue_update = resolve & (Branch_D | pred_taken_q);
    end

    always_comb begin
        vld_d         = vld_q;
        pred_taken_d  = pred_taken_q;
        pred_target_d = pred_target_q;
        pc_d          = pc_q;
        pc_plus4_d    = pc_plus4_q;
        if (!stall_D) begin
            vld_d         = 1'b1;
            pred_taken_d  = pred_taken_F;
            pred_target_d = pred_target_F;
            pc_d          = PC_F;
            pc_plus4_d    = PCPlus4_F;
        end
        if (flush_D) begin
            vld_d = 1'b0;
        end
    end

    always_comb begin
        upd_en_d     = issue_update;
        upd_pc_d     = upd_pc_q;
        upd_target_d = upd_target_q;
        upd_taken_d  = upd_taken_q;
        if (issue_update) begin
            upd_pc_d     = pc_q;
            upd_target_d = Branch_D ? PCBranch_D : pc_plus4_q;
            upd_taken_d  = Branch_D & branch_taken_D;
        end
    end

    always_comb begin
        branch_cnt_d     = branch_cnt_q;
        mispredict_cnt_d = mispredict_cnt_q;
        if (resolve && Branch_D && (branch_cnt_q != {CNT_W{1'b1}})) begin
            branch_cnt_d = branch_cnt_q + 1'b1;
        end
        if (mispredict && (mispredict_cnt_q != {CNT_W{1'b1}})) begin
            mispredict_cnt_d = mispredict_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q            <= 1'b0;
            pred_taken_q     <= 1'b0;
            pred_target_q    <= '0;
            pc_q             <= '0;
            pc_plus4_q       <= '0;
            upd_en_q         <= 1'b0;
            upd_pc_q         <= '0;
            upd_target_q     <= '0;
            upd_taken_q      <= 1'b0;
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            vld_q            <= vld_d;
            pred_taken_q     <= pred_taken_d;
            pred_target_q    <= pred_target_d;
            pc_q             <= pc_d;
            pc_plus4_q       <= pc_plus4_d;
            upd_en_q         <= upd_en_d;
            upd_pc_q         <= upd_pc_d;
            upd_target_q     <= upd_target_d;
            upd_taken_q      <= upd_taken_d;
            branch_cnt_q     <= branch_cnt_d;
            mispredict_cnt_q <= mispredict_cnt_d;
        end
    end

    assign update_en      = upd_en_q;
    assign update_pc      = upd_pc_q;
    assign update_target  = upd_target_q;
    assign update_taken   = upd_taken_q;
    assign branch_cnt     = branch_cnt_q;
    assign mispredict_cnt = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_resolution_unit.sv
// Bench for branch_resolution_unit: outcome-level reference model checked every cycle, plus
// directed scenarios with literal expectations; a second instance uses 2-bit counters.
module tb_branch_resolution_unit;

    logic        clk;
    logic        rst;
    logic        stall_D;
    logic        pred_taken_F;
    logic [31:0] pred_target_F;
    logic [31:0] PC_F;
    logic [31:0] PCPlus4_F;
    logic        Branch_D;
    logic        branch_taken_D;
    logic [31:0] PCBranch_D;

    logic        flush_D, redirect_valid, update_en, update_taken;
    logic [31:0] redirect_pc, update_pc, update_target;
    logic [15:0] branch_cnt, mispredict_cnt;

    logic        s_flush_D, s_redirect_valid, s_update_en, s_update_taken;
    logic [31:0] s_redirect_pc, s_update_pc, s_update_target;
    logic [1:0]  s_branch_cnt, s_mispredict_cnt;

    int errors = 0;
    int checks = 0;

    branch_resolution_unit #(.ADDR_W(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .stall_D(stall_D), .pred_taken_F(pred_taken_F),
        .pred_target_F(pred_target_F), .PC_F(PC_F), .PCPlus4_F(PCPlus4_F),
        .Branch_D(Branch_D), .branch_taken_D(branch_taken_D), .PCBranch_D(PCBranch_D),
        .flush_D(flush_D), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .update_en(update_en), .update_pc(update_pc), .update_target(update_target),
        .update_taken(update_taken), .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
    );

    branch_resolution_unit #(.ADDR_W(32), .CNT_W(2)) dut_small (
        .clk(clk), .rst(rst), .stall_D(stall_D), .pred_taken_F(pred_taken_F),
        .pred_target_F(pred_target_F), .PC_F(PC_F), .PCPlus4_F(PCPlus4_F),
        .Branch_D(Branch_D), .branch_taken_D(branch_taken_D), .PCBranch_D(PCBranch_D),
        .flush_D(s_flush_D), .redirect_valid(s_redirect_valid), .redirect_pc(s_redirect_pc),
        .update_en(s_update_en), .update_pc(s_update_pc), .update_target(s_update_target),
        .update_taken(s_update_taken), .branch_cnt(s_branch_cnt),
        .mispredict_cnt(s_mispredict_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: the instruction sitting in Decode and the outcome-level consequences.
    logic        m_vld, m_pred;
    logic [31:0] m_tgt, m_pc, m_pc4;
    logic        m_uen, m_utk;
    logic [31:0] m_upc, m_utgt;
    int          m_bcnt, m_mcnt;
    logic        m_res, act_tk, e_mis;
    logic [31:0] e_rpc;

    always_comb begin
        m_res  = m_vld & ~stall_D;
        act_tk = Branch_D & branch_taken_D;
        // Wrong if the guessed direction differs, or taken-both-ways but to the wrong place.
        e_mis  = m_res & ((m_pred != act_tk) | (m_pred & act_tk & (m_tgt != PCBranch_D)));
        e_rpc  = act_tk ? PCBranch_D : m_pc4;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_vld <= 1'b0; m_pred <= 1'b0; m_tgt <= '0; m_pc <= '0; m_pc4 <= '0;
            m_uen <= 1'b0; m_utk <= 1'b0; m_upc <= '0; m_utgt <= '0;
            m_bcnt <= 0; m_mcnt <= 0;
        end else begin
            if (!stall_D) begin
                m_vld <= ~e_mis; m_pred <= pred_taken_F; m_tgt <= pred_target_F;
                m_pc <= PC_F; m_pc4 <= PCPlus4_F;
            end
            m_uen <= m_res & (Branch_D | m_pred);
            if (m_res & (Branch_D | m_pred)) begin
                m_upc  <= m_pc;
                m_utgt <= Branch_D ? PCBranch_D : m_pc4;
                m_utk  <= act_tk;
            end
            if (m_res & Branch_D) m_bcnt <= m_bcnt + 1;
            if (e_mis) m_mcnt <= m_mcnt + 1;
        end
    end

    always @(negedge clk) begin
        chk("flush_D", 32'(flush_D), 32'(e_mis));
        chk("redirect_valid", 32'(redirect_valid), 32'(e_mis));
        if (e_mis) chk("redirect_pc", redirect_pc, e_rpc);
        if (rst) chk("redirect_pc_rst", redirect_pc, 32'h0);
        chk("update_en", 32'(update_en), 32'(m_uen));
        chk("update_pc", update_pc, m_upc);
        chk("update_target", update_target, m_utgt);
        chk("update_taken", 32'(update_taken), 32'(m_utk));
        chk("branch_cnt", 32'(branch_cnt), 32'((m_bcnt > 65535) ? 65535 : m_bcnt));
        chk("mispredict_cnt", 32'(mispredict_cnt), 32'((m_mcnt > 65535) ? 65535 : m_mcnt));
        chk("s_flush_D", 32'(s_flush_D), 32'(e_mis));
        chk("s_update_en", 32'(s_update_en), 32'(m_uen));
        chk("s_branch_cnt", 32'(s_branch_cnt), 32'((m_bcnt > 3) ? 3 : m_bcnt));
        chk("s_mispredict_cnt", 32'(s_mispredict_cnt), 32'((m_mcnt > 3) ? 3 : m_mcnt));
    end

    task automatic set_f(input logic [31:0] pc, input logic pt, input logic [31:0] tgt);
        PC_F = pc; PCPlus4_F = pc + 32'd4; pred_taken_F = pt; pred_target_F = tgt;
    endtask

    task automatic set_d(input logic br, input logic bt, input logic [31:0] pcb);
        Branch_D = br; branch_taken_D = bt; PCBranch_D = pcb;
    endtask

    task automatic mid;
        @(negedge clk);
        #1;
    endtask

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; stall_D = 1'b0;
        set_f(32'h0, 1'b0, 32'h0);
        set_d(1'b0, 1'b0, 32'h0);
        mid;
        chk("rst_flush", 32'(flush_D), 32'h0);
        chk("rst_redirect_pc", redirect_pc, 32'h0);
        chk("rst_update_en", 32'(update_en), 32'h0);
        chk("rst_branch_cnt", 32'(branch_cnt), 32'h0);
        rst = 1'b0;

        // Correctly predicted taken branch
        set_f(32'h30, 1'b1, 32'h40); set_d(1'b0, 1'b0, 32'h0); nxt;
        set_d(1'b1, 1'b1, 32'h40); set_f(32'h40, 1'b0, 32'h0); mid;
        chk("t1_flush", 32'(flush_D), 32'h0);
        nxt;
        set_d(1'b0, 1'b0, 32'h0); set_f(32'h10, 1'b0, 32'h0); mid;
        chk("t1_update_en", 32'(update_en), 32'h1);
        chk("t1_update_taken", 32'(update_taken), 32'h1);
        chk("t1_update_pc", update_pc, 32'h30);
        chk("t1_branch_cnt", 32'(branch_cnt), 32'h1);
        chk("t1_mispredict_cnt", 32'(mispredict_cnt), 32'h0);
        nxt;

        // Predicted not-taken, actually taken; wrong-path fetch predicts taken but is killed
        set_d(1'b1, 1'b1, 32'h80); set_f(32'h14, 1'b1, 32'h99); mid;
        chk("t2_flush", 32'(flush_D), 32'h1);
        chk("t2_redirect_pc", redirect_pc, 32'h80);
        nxt;
        set_d(1'b0, 1'b0, 32'h0); set_f(32'h10, 1'b1, 32'h80); mid;
        chk("t2_no_double_flush", 32'(flush_D), 32'h0);
        chk("t2_mispredict_cnt", 32'(mispredict_cnt), 32'h1);
        nxt;

        // Predicted taken, resolves not-taken
        set_d(1'b1, 1'b0, 32'h80); set_f(32'h84, 1'b0, 32'h0); mid;
        chk("t3_flush", 32'(flush_D), 32'h1);
        chk("t3_redirect_pc", redirect_pc, 32'h14);
        nxt;
        set_d(1'b0, 1'b0, 32'h0); set_f(32'h20, 1'b1, 32'h80); mid;
        chk("t3_update_taken", 32'(update_taken), 32'h0);
        chk("t3_update_target", update_target, 32'h80);
        nxt;

        // Direction right, target wrong
        set_d(1'b1, 1'b1, 32'h90); set_f(32'h84, 1'b0, 32'h0); mid;
        chk("t4_flush", 32'(flush_D), 32'h1);
        chk("t4_redirect_pc", redirect_pc, 32'h90);
        nxt;

        // BTB alias: non-branch predicted taken
        set_d(1'b0, 1'b0, 32'h0); set_f(32'h50, 1'b1, 32'h60); mid;
        chk("t4_mispredict_cnt", 32'(mispredict_cnt), 32'h3);
        nxt;
        set_d(1'b0, 1'b0, 32'h0); set_f(32'h58, 1'b0, 32'h0); mid;
        chk("alias_flush", 32'(flush_D), 32'h1);
        chk("alias_redirect_pc", redirect_pc, 32'h54);
        nxt;
        set_f(32'h100, 1'b0, 32'h0); mid;
        chk("alias_update_taken", 32'(update_taken), 32'h0);
        chk("alias_update_target", update_target, 32'h54);
        chk("alias_s_mispredict_sat", 32'(s_mispredict_cnt), 32'h3);
        nxt;

        // Mispredicting branch held in Decode by a 3-cycle stall
        stall_D = 1'b1; set_d(1'b1, 1'b1, 32'h200);
        for (int i = 0; i < 3; i++) begin
            set_f(32'h900 + 32'(i * 16), 1'b1, 32'h700); mid;
            chk("t5_stall_flush", 32'(flush_D), 32'h0);
            chk("t5_stall_update_en", 32'(update_en), 32'h0);
            nxt;
        end
        stall_D = 1'b0; set_f(32'h104, 1'b0, 32'h0); mid;
        chk("t5_flush", 32'(flush_D), 32'h1);
        chk("t5_redirect_pc", redirect_pc, 32'h200);
        nxt;
        set_d(1'b0, 1'b0, 32'h0); set_f(32'h300, 1'b0, 32'h0); mid;
        chk("t5_branch_cnt", 32'(branch_cnt), 32'h5);
        chk("t5_mispredict_cnt", 32'(mispredict_cnt), 32'h5);
        chk("t5_update_pc", update_pc, 32'h100);
        chk("t6_s_mispredict_sat", 32'(s_mispredict_cnt), 32'h3);
        nxt;

        // Reset in the middle of a redirect
        set_d(1'b1, 1'b1, 32'h400); set_f(32'h304, 1'b0, 32'h0); mid;
        chk("t6_pre_rst_flush", 32'(flush_D), 32'h1);
        rst = 1'b1;
        #1;
        chk("t6_rst_flush", 32'(flush_D), 32'h0);
        chk("t6_rst_redirect_valid", 32'(redirect_valid), 32'h0);
        chk("t6_rst_redirect_pc", redirect_pc, 32'h0);
        chk("t6_rst_update_pc", update_pc, 32'h0);
        chk("t6_rst_branch_cnt", 32'(branch_cnt), 32'h0);
        chk("t6_rst_mispredict_cnt", 32'(mispredict_cnt), 32'h0);
        mid;
        rst = 1'b0;
        set_f(32'h500, 1'b1, 32'h600); set_d(1'b0, 1'b0, 32'h0); nxt;
        set_d(1'b1, 1'b1, 32'h600); set_f(32'h604, 1'b0, 32'h0); mid;
        chk("t6_post_flush", 32'(flush_D), 32'h0);
        nxt;
        set_d(1'b0, 1'b0, 32'h0); mid;
        chk("t6_post_update_en", 32'(update_en), 32'h1);
        chk("t6_post_update_pc", update_pc, 32'h500);
        chk("t6_post_update_target", update_target, 32'h600);
        chk("t6_post_branch_cnt", 32'(branch_cnt), 32'h1);
        chk("t6_post_mispredict_cnt", 32'(mispredict_cnt), 32'h0);
        nxt;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
